// File: rtl/map_frame_scanner_pkg.sv
// Shared game constants: screen geometry, terrain colours and the scanner state encoding.
// Imported by the map scanner, the plot adapter and the map writer.
package map_frame_scanner_pkg;

  localparam int SCREEN_COLS = 160;
  localparam int SCREEN_ROWS = 120;

  localparam logic [2:0] COLOUR_SKY    = 3'b011;
  localparam logic [2:0] COLOUR_GROUND = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DRAW,
    S_NEXT,
    S_SWAP
  } scan_state_e;

endpackage

// File: rtl/map_frame_scanner.sv
// Scans the read-side map RAM one column per pass, turns each ground height into a
// vertical run of sky/ground plot commands, then pulses map to swap the double buffer.
module map_frame_scanner
  import map_frame_scanner_pkg::*;
#(
  parameter int         COLS   = SCREEN_COLS,
  parameter int         ROWS   = SCREEN_ROWS,
  parameter logic [2:0] SKY    = COLOUR_SKY,
  parameter logic [2:0] GROUND = COLOUR_GROUND
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       ram1_read_en,
  input  logic       ram2_read_en,
  input  logic [7:0] ram1_q,
  input  logic [7:0] ram2_q,
  output logic [7:0] rd_addr,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       map
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);
  localparam logic [7:0] ROWS_W   = 8'(ROWS);

  scan_state_e r_state, w_next_state;

  logic [7:0] r_col, w_col_next;
  logic [6:0] r_row, w_row_next;
  logic [7:0] r_h,   w_h_next;

  logic [7:0] r_rd_addr;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_busy;
  logic       r_map;

  logic       w_sel_ram2;
  logic [7:0] w_raw_h;
  logic [7:0] w_clamped_h;
  logic       w_last_row;
  logic       w_pix_valid;
  logic [2:0] w_pix_colour;

  // RAM1 wins whenever the enables are ambiguous (both or neither set).
  assign w_sel_ram2  = ram2_read_en & ~ram1_read_en;
  assign w_raw_h     = w_sel_ram2 ? ram2_q : ram1_q;
  assign w_clamped_h = (w_raw_h > ROWS_W) ? ROWS_W : w_raw_h;
  assign w_last_row  = (r_row == LAST_ROW);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_h_next     = r_h;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_col_next   = '0;
          w_row_next   = '0;
        end
      end
      S_FETCH: w_next_state = S_LATCH;
      S_LATCH: begin
        w_h_next     = w_clamped_h;
        w_next_state = S_DRAW;
      end
      S_DRAW: begin
        if (w_last_row) begin
          w_row_next   = '0;
          w_next_state = S_NEXT;
        end else begin
          w_row_next = r_row + 7'd1;
        end
      end
      S_NEXT: begin
        if (r_col == LAST_COL) begin
          w_next_state = S_SWAP;
        end else begin
          w_col_next   = r_col + 8'd1;
          w_next_state = S_FETCH;
        end
      end
      S_SWAP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Plot outputs are registered from the next-state values so the pixel for row r
  // appears in the same cycle the row counter holds r.
  assign w_pix_valid  = (w_next_state == S_DRAW);
  assign w_pix_colour = ({1'b0, w_row_next} >= (ROWS_W - w_h_next)) ? GROUND : SKY;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_h       <= '0;
      r_rd_addr <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
      r_map     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_h     <= w_h_next;
      if (w_next_state == S_FETCH) begin
        r_rd_addr <= w_col_next;
      end
      if (w_pix_valid) begin
        r_x      <= w_col_next;
        r_y      <= w_row_next;
        r_colour <= w_pix_colour;
      end
      r_plot <= w_pix_valid;
      r_busy <= (w_next_state != S_IDLE);
      r_map  <= (w_next_state == S_SWAP);
    end
  end

  assign rd_addr = r_rd_addr;
  assign x       = r_x;
  assign y       = r_y;
  assign colour  = r_colour;
  assign plot    = r_plot;
  assign busy    = r_busy;
  assign map     = r_map;

endmodule

// File: tb/tb_map_frame_scanner.sv
// Directed bench for map_frame_scanner: RAM models, a pixel monitor with a height
// model, and frame-level checks on plot count, colours, map timing and reset abort.
module tb_map_frame_scanner;

  localparam int         COLS       = 160;
  localparam int         ROWS       = 120;
  localparam logic [2:0] SKY_C      = 3'b011;
  localparam logic [2:0] GROUND_C   = 3'b010;
  localparam int         SWAP_OFS   = 19681;
  localparam int         FRAME_BUDGET = 20000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       ram1_read_en;
  logic       ram2_read_en;
  logic [7:0] ram1_q;
  logic [7:0] ram2_q;
  logic [7:0] rd_addr;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       map;

  always #5 clk = ~clk;

  map_frame_scanner dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .ram1_read_en (ram1_read_en),
    .ram2_read_en (ram2_read_en),
    .ram1_q       (ram1_q),
    .ram2_q       (ram2_q),
    .rd_addr      (rd_addr),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .map          (map)
  );

  logic [7:0] ram1 [0:COLS-1];
  logic [7:0] ram2 [0:COLS-1];

  always @(posedge clk) begin
    ram1_q <= (rd_addr < COLS) ? ram1[rd_addr] : 8'hxx;
    ram2_q <= (rd_addr < COLS) ? ram2[rd_addr] : 8'hxx;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] model_colour(input int xx, input int yy);
    int h;
    if (xx >= COLS) return 3'b111;
    if (ram2_read_en && !ram1_read_en) h = int'(ram2[xx]);
    else h = int'(ram1[xx]);
    if (h > ROWS) h = ROWS;
    return (yy >= ROWS - h) ? GROUND_C : SKY_C;
  endfunction

  // Frame statistics, cleared whenever the stimulus thread bumps frame_id.
  int frame_id = 0;
  int seen_id = 0;
  int plot_cnt = 0, bad_pix = 0, sky_cnt = 0;
  int map_cnt = 0, map_cyc = -1, map_double = 0;
  int first_plot_cyc = -1, first_x = -1, first_y = -1;
  int gnd_col [0:COLS-1];
  logic map_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_id != seen_id) begin
      seen_id        <= frame_id;
      plot_cnt       <= 0;
      bad_pix        <= 0;
      sky_cnt        <= 0;
      map_cnt        <= 0;
      map_cyc        <= -1;
      map_double     <= 0;
      first_plot_cyc <= -1;
      first_x        <= -1;
      first_y        <= -1;
      for (int i = 0; i < COLS; i++) gnd_col[i] <= 0;
    end else begin
      if (plot === 1'b1) begin
        if (plot_cnt == 0) begin
          first_plot_cyc <= cyc;
          first_x        <= int'(x);
          first_y        <= int'(y);
        end
        if (int'(x) != plot_cnt / ROWS || int'(y) != plot_cnt % ROWS ||
            colour !== model_colour(int'(x), int'(y)))
          bad_pix <= bad_pix + 1;
        if (colour === GROUND_C && x < COLS) gnd_col[x] <= gnd_col[x] + 1;
        if (colour === SKY_C) sky_cnt <= sky_cnt + 1;
        plot_cnt <= plot_cnt + 1;
      end
      if (map === 1'b1) begin
        map_cnt <= map_cnt + 1;
        map_cyc <= cyc;
        if (map_prev) map_double <= map_double + 1;
      end
    end
    map_prev <= map;
  end

  int n_checks = 0;
  int n_errors = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame();
    tick();
    frame_id  = frame_id + 1;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_start_at(input int ofs);
    while (cyc < start_cyc + ofs) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_map"}, map, 0);
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    while (map_cnt == 0 && n < FRAME_BUDGET) begin
      tick();
      n++;
    end
    check({tag, "_map_seen"}, map_cnt, 1);
    check({tag, "_map_cycle"}, map_cyc - start_cyc, SWAP_OFS);
    tick();
    check({tag, "_busy_after_swap"}, busy, 0);
    repeat (5) tick();
    check({tag, "_map_once"}, map_cnt, 1);
    check({tag, "_map_double"}, map_double, 0);
    check({tag, "_plots"}, plot_cnt, COLS * ROWS);
    check({tag, "_pixels"}, bad_pix, 0);
  endtask

  initial begin
    int n;
    int p;
    resetn       = 1'b0;
    start        = 1'b0;
    ram1_read_en = 1'b1;
    ram2_read_en = 1'b0;
    for (int i = 0; i < COLS; i++) begin
      ram1[i] = 8'((i * 3) % 128);
      ram2[i] = 8'd77;
    end
    ram1[0] = 8'd30;
    ram1[5] = 8'd200;
    ram1[6] = 8'd120;

    repeat (3) tick();
    check_outputs_zero("reset");
    resetn = 1'b1;
    tick();

    // Frame A: RAM1 heights including clamp and exact-ROWS columns.
    start_frame();
    check("a_busy_fetch", busy, 1);
    check("a_rd_addr_fetch", rd_addr, 0);
    finish_frame("a");
    check("a_first_plot_ofs", first_plot_cyc - start_cyc, 3);
    check("a_col0_ground", gnd_col[0], 30);
    check("a_col5_clamp", gnd_col[5], ROWS);
    check("a_col6_full", gnd_col[6], ROWS);

    // Frame B: flat map, with stray start pulses mid-scan.
    for (int i = 0; i < COLS; i++) ram1[i] = 8'd0;
    start_frame();
    pulse_start_at(50);
    pulse_start_at(1000);
    finish_frame("b");
    check("b_all_sky", sky_cnt, COLS * ROWS);

    // Frame C: RAM2 selected, aborted by reset during column 40.
    ram1_read_en = 1'b0;
    ram2_read_en = 1'b1;
    for (int i = 0; i < COLS; i++) ram2[i] = 8'((i * 7) % 130);
    ram2[0] = 8'd10;
    ram1[0] = 8'd50;
    start_frame();
    n = 0;
    while (!(plot === 1'b1 && x == 8'd40) && n < 6000) begin
      tick();
      n++;
    end
    check("c_reached_col40", (plot === 1'b1 && x == 8'd40), 1);
    resetn = 1'b0;
    tick();
    check_outputs_zero("c_abort");
    check("c_col0_ram2", gnd_col[0], 10);
    check("c_pixels", bad_pix, 0);
    resetn = 1'b1;
    p = plot_cnt;
    repeat (300) tick();
    check("c_no_map", map_cnt, 0);
    check("c_idle_busy", busy, 0);
    check("c_no_plot_after_abort", plot_cnt, p);

    // Frame D: restart after abort with both enables set, RAM1 is the source.
    ram1_read_en = 1'b1;
    ram2_read_en = 1'b1;
    start_frame();
    check("d_rd_addr_restart", rd_addr, 0);
    n = 0;
    while (plot_cnt < 2 * ROWS && n < 400) begin
      tick();
      n++;
    end
    check("d_first_plot_ofs", first_plot_cyc - start_cyc, 3);
    check("d_first_x", first_x, 0);
    check("d_first_y", first_y, 0);
    check("d_col0_ram1_default", gnd_col[0], 50);
    check("d_pixels", bad_pix, 0);
    resetn = 1'b0;
    tick();
    check_outputs_zero("d_abort");
    resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
